mmu_seq: RTL and testbench

MMU_SEQ -- requirements
Module: mmu_seq

---
 rtl/mmu_seq.sv | 165 ++++++++++++++++
 tb/tb_mmu_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_seq.sv
// mmu_seq: sequential fixed-point matrix multiplier, C = A*B (+ ACC).
// One inner-product step (k) per cycle for all (i,j) in parallel; the result
// is shifted back to Q format, saturated, and held until the next product.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request a product (accepted only when idle)
//   accum_en          add mat_in_accum into the product (sampled with start)
//   mat_in1/2         matrices A [ROWS x K] and B [K x COLS]
//   mat_in_accum      matrix ACC [ROWS x COLS]
//   busy              high while a product is in flight
//   mat_out           result C, held until the next result
//   data_ready        one-cycle pulse when mat_out is updated
//   sat_flag          any element of mat_out was clipped
module mmu_seq #(
  parameter int unsigned NUM_ROWS_A = 2,
  parameter int unsigned NUM_COLS_A = 2,
  parameter int unsigned NUM_COLS_B = 2,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIXED_PNT  = 8
) (
  input  logic                                                        clk,
  input  logic                                                        rst,
  input  logic                                                        start,
  input  logic                                                        accum_en,
  input  logic signed [NUM_ROWS_A-1:0][NUM_COLS_A-1:0][DATA_WIDTH-1:0] mat_in1,
  input  logic signed [NUM_COLS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mat_in2,
  input  logic signed [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mat_in_accum,
  output logic                                                        busy,
  output logic signed [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mat_out,
  output logic                                                        data_ready,
  output logic                                                        sat_flag
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = 2 * DATA_WIDTH + $clog2(NUM_COLS_A) + 1;
  localparam int unsigned KW = (NUM_COLS_A > 1) ? $clog2(NUM_COLS_A) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [NUM_ROWS_A-1:0][NUM_COLS_A-1:0][DW-1:0] a_q, a_d;
  logic [NUM_COLS_A-1:0][NUM_COLS_B-1:0][DW-1:0] b_q, b_d;
  logic signed [AW-1:0] acc_q [NUM_ROWS_A][NUM_COLS_B];
  logic signed [AW-1:0] acc_d [NUM_ROWS_A][NUM_COLS_B];
  logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DW-1:0] mat_out_q, mat_out_d;
  logic          sat_q, sat_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;

  logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DW-1:0] clip_c;
  logic          sat_any_c;

  // Rescale each accumulator (floor) and clip to the element range.
  always_comb begin
    logic signed [AW-1:0] sh;
    sat_any_c = 1'b0;
    clip_c    = '0;
    for (int i = 0; i < NUM_ROWS_A; i++) begin
      for (int j = 0; j < NUM_COLS_B; j++) begin
        sh = acc_q[i][j] >>> FIXED_PNT;
        if (sh > SAT_MAX) begin
          clip_c[i][j] = SAT_MAX[DW-1:0];
          sat_any_c    = 1'b1;
        end else if (sh < SAT_MIN) begin
          clip_c[i][j] = SAT_MIN[DW-1:0];
          sat_any_c    = 1'b1;
        end else begin
          clip_c[i][j] = sh[DW-1:0];
        end
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    mat_out_d = mat_out_q;
    sat_d     = sat_q;
    busy_d    = busy_q;
    ready_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = mat_in1;
          b_d    = mat_in2;
          k_d    = '0;
          busy_d = 1'b1;
          for (int i = 0; i < NUM_ROWS_A; i++) begin
            for (int j = 0; j < NUM_COLS_B; j++) begin
              acc_d[i][j] = accum_en ? (AW'($signed(mat_in_accum[i][j])) <<< FIXED_PNT) : '0;
            end
          end
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        for (int i = 0; i < NUM_ROWS_A; i++) begin
          for (int j = 0; j < NUM_COLS_B; j++) begin
            acc_d[i][j] = acc_q[i][j] +
                          AW'($signed(a_q[i][k_q])) * AW'($signed(b_q[k_q][j]));
          end
        end
        if (k_q == KW'(NUM_COLS_A - 1)) begin
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        mat_out_d = clip_c;
        sat_d     = sat_any_c;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mat_out_q <= '0;
      sat_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      for (int i = 0; i < NUM_ROWS_A; i++) begin
        for (int j = 0; j < NUM_COLS_B; j++) begin
          acc_q[i][j] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mat_out_q <= mat_out_d;
      sat_q     <= sat_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      acc_q     <= acc_d;
    end
  end

  assign busy       = busy_q;
  assign mat_out    = mat_out_q;
  assign data_ready = ready_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_mmu_seq.sv
// Testbench for mmu_seq: a 2x2x2 instance checked every cycle against a
// countdown/arithmetic model, plus 1x2x1 and 1x1x1 instances for directed
// saturation, rounding and K=1 latency cases.
module tb_mmu_seq;

  typedef logic signed [1:0][1:0][15:0] mat22_t;
  typedef struct packed { mat22_t m; logic s; } res22_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 2x2x2 instance
  logic   start = 1'b0, accum_en = 1'b0;
  mat22_t a22 = '0, b22 = '0, c22 = '0, out22;
  logic   busy22, dr22, sat22;

  mmu_seq u_222 (
    .clk(clk), .rst(rst), .start(start), .accum_en(accum_en),
    .mat_in1(a22), .mat_in2(b22), .mat_in_accum(c22),
    .busy(busy22), .mat_out(out22), .data_ready(dr22), .sat_flag(sat22)
  );

  // 1x2x1 instance
  logic s121 = 1'b0;
  logic signed [0:0][1:0][15:0] a121 = '0;
  logic signed [1:0][0:0][15:0] b121 = '0;
  logic signed [0:0][0:0][15:0] c121 = '0, out121;
  logic busy121, dr121, sat121;

  mmu_seq #(.NUM_ROWS_A(1), .NUM_COLS_A(2), .NUM_COLS_B(1)) u_121 (
    .clk(clk), .rst(rst), .start(s121), .accum_en(1'b0),
    .mat_in1(a121), .mat_in2(b121), .mat_in_accum(c121),
    .busy(busy121), .mat_out(out121), .data_ready(dr121), .sat_flag(sat121)
  );

  // 1x1x1 instance
  logic s111 = 1'b0;
  logic signed [0:0][0:0][15:0] a111 = '0, b111 = '0, c111 = '0, out111;
  logic busy111, dr111, sat111;

  mmu_seq #(.NUM_ROWS_A(1), .NUM_COLS_A(1), .NUM_COLS_B(1)) u_111 (
    .clk(clk), .rst(rst), .start(s111), .accum_en(1'b0),
    .mat_in1(a111), .mat_in2(b111), .mat_in_accum(c111),
    .busy(busy111), .mat_out(out111), .data_ready(dr111), .sat_flag(sat111)
  );

  int ctests = 0, cfails = 0;   // per-cycle compare process
  int dtests = 0, dfails = 0;   // directed checks
  logic chk_en = 1'b0;

  function automatic mat22_t mk22(input int e00, input int e01, input int e10, input int e11);
    mat22_t m;
    m[0][0] = 16'(e00); m[0][1] = 16'(e01);
    m[1][0] = 16'(e10); m[1][1] = 16'(e11);
    return m;
  endfunction

  // Reference arithmetic: exact integer sum, floor divide by 2^8, clip.
  function automatic res22_t model22(input mat22_t a, input mat22_t b, input mat22_t c, input logic en);
    res22_t r;
    longint s;
    r.s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = en ? longint'($signed(c[i][j])) * 256 : 64'sd0;
        for (int k = 0; k < 2; k++) begin
          s += longint'($signed(a[i][k])) * longint'($signed(b[k][j]));
        end
        s = s >>> 8;
        if (s > 32767) begin
          r.m[i][j] = 16'sh7fff; r.s = 1'b1;
        end else if (s < -32768) begin
          r.m[i][j] = 16'sh8000; r.s = 1'b1;
        end else begin
          r.m[i][j] = 16'(s);
        end
      end
    end
    return r;
  endfunction

  // Timing model: a product occupies K+1 = 3 edges after acceptance.
  res22_t cur;
  assign cur = model22(a22, b22, c22, accum_en);

  int     m_cnt = 0;
  mat22_t m_out = '0, p_out = '0;
  logic   m_sat = 1'b0, p_sat = 1'b0, m_dr = 1'b0;

  always @(posedge clk) begin
    m_dr <= 1'b0;
    if (rst) begin
      m_cnt <= 0;
      m_out <= '0;
      m_sat <= 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt <= 3;
        p_out <= cur.m;
        p_sat <= cur.s;
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_out <= p_out;
        m_sat <= p_sat;
        m_dr  <= 1'b1;
      end
    end
  end

  // Per-cycle comparison of the 2x2x2 instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      ctests++;
      if (busy22 !== (m_cnt != 0)) begin
        cfails++; $display("FAIL busy t=%0t got %b want %b", $time, busy22, (m_cnt != 0));
      end
      ctests++;
      if (dr22 !== m_dr) begin
        cfails++; $display("FAIL data_ready t=%0t got %b want %b", $time, dr22, m_dr);
      end
      ctests++;
      if (sat22 !== m_sat) begin
        cfails++; $display("FAIL sat_flag t=%0t got %b want %b", $time, sat22, m_sat);
      end
      ctests++;
      if (out22 !== m_out) begin
        cfails++; $display("FAIL mat_out t=%0t got %h want %h", $time, out22, m_out);
      end
    end
  end

  task automatic dcheck(input string name, input logic ok, input longint got, input longint want);
    dtests++;
    if (!ok) begin
      dfails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic mat22_t rnd22();
    mat22_t m;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        case ($urandom_range(0, 3))
          0: m[i][j] = 16'($signed($urandom_range(0, 2048)) - 1024);
          1: m[i][j] = 16'($urandom);
          2: m[i][j] = 16'sh7fff;
          default: m[i][j] = 16'sh8000;
        endcase
    return m;
  endfunction

  // One product on the 2x2x2 instance with latency and literal result checks.
  task automatic run222(input string name, input mat22_t a, input mat22_t b, input mat22_t c,
                        input logic en, input mat22_t want, input logic scramble);
    int n;
    @(negedge clk);
    a22 = a; b22 = b; c22 = c; accum_en = en; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      a22 = rnd22(); b22 = rnd22(); c22 = rnd22(); accum_en = ~en;
    end
    n = 1;
    while (!dr22 && n < 20) begin
      @(negedge clk); n++;
    end
    dcheck({name, "_latency"}, dr22 === 1'b1 && n == 4, n, 4);
    dcheck({name, "_out"}, out22 === want, longint'($signed(out22[1][1])), longint'($signed(want[1][1])));
    dcheck({name, "_sat"}, sat22 === 1'b0, longint'(sat22), 0);
  endtask

  task automatic run121(input string name, input int a0, input int a1, input int b0, input int b1,
                        input int want, input logic wsat);
    int n;
    @(negedge clk);
    a121[0][0] = 16'(a0); a121[0][1] = 16'(a1);
    b121[0][0] = 16'(b0); b121[1][0] = 16'(b1);
    s121 = 1'b1;
    @(negedge clk);
    s121 = 1'b0;
    n = 1;
    while (!dr121 && n < 20) begin
      @(negedge clk); n++;
    end
    dcheck({name, "_latency"}, dr121 === 1'b1 && n == 4, n, 4);
    dcheck({name, "_out"}, out121[0][0] === 16'(want), longint'($signed(out121[0][0])), want);
    dcheck({name, "_sat"}, sat121 === wsat, longint'(sat121), longint'(wsat));
  endtask

  task automatic run111(input string name, input int a, input int b, input int want, input logic wsat);
    int n;
    @(negedge clk);
    a111[0][0] = 16'(a); b111[0][0] = 16'(b);
    s111 = 1'b1;
    @(negedge clk);
    s111 = 1'b0;
    n = 1;
    while (!dr111 && n < 20) begin
      @(negedge clk); n++;
    end
    dcheck({name, "_latency"}, dr111 === 1'b1 && n == 3, n, 3);
    dcheck({name, "_out"}, out111[0][0] === 16'(want), longint'($signed(out111[0][0])), want);
    dcheck({name, "_sat"}, sat111 === wsat, longint'(sat111), longint'(wsat));
  endtask

  initial begin
    mat22_t ra, rb, racc, w1, w0;
    res22_t mr;
    int     seen;

    ra   = mk22(256, 512, 768, 384);
    rb   = mk22(1024, 768, 512, 640);
    racc = mk22(256, 256, 256, 256);
    w1   = mk22(2304, 2304, 4096, 3520);
    w0   = mk22(2048, 2048, 3840, 3264);

    // Pin the model against hand-computed products.
    mr = model22(ra, rb, racc, 1'b1);
    dcheck("model_accum", mr.m === w1 && mr.s == 1'b0, longint'($signed(mr.m[1][1])), 3520);
    mr = model22(ra, rb, racc, 1'b0);
    dcheck("model_noaccum", mr.m === w0, longint'($signed(mr.m[1][0])), 3840);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    dcheck("reset_out22", out22 === '0 && busy22 === 1'b0 && dr22 === 1'b0 && sat22 === 1'b0,
           longint'(busy22), 0);
    dcheck("reset_small", out121 === '0 && out111 === '0 && sat121 === 1'b0 && sat111 === 1'b0,
           longint'($signed(out111[0][0])), 0);

    run222("accum", ra, rb, racc, 1'b1, w1, 1'b0);
    run222("noaccum_scramble", ra, rb, racc, 1'b0, w0, 1'b1);

    run121("sat_pos", 32767, 32767, 32767, 32767, 32767, 1'b1);
    run121("sat_neg", -32767, -32767, 32767, 32767, -32768, 1'b1);
    run121("plain", 256, 256, 256, 512, 768, 1'b0);
    run111("floor_neg", -1, 1, -1, 1'b0);
    run111("floor_pos", 1, 1, 0, 1'b0);
    run111("sat_k1", -32768, -32768, 32767, 1'b1);

    // Random traffic with occasional resets; inputs change every cycle.
    repeat (400) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 49) == 0);
      start    = 1'($urandom_range(0, 1));
      accum_en = 1'($urandom_range(0, 1));
      a22 = rnd22(); b22 = rnd22(); c22 = rnd22();
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    // Start held continuously.
    repeat (24) begin
      @(negedge clk);
      start = 1'b1;
      a22 = rnd22(); b22 = rnd22(); c22 = rnd22();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);

    // Reset during the first compute cycle aborts the product.
    a22 = ra; b22 = rb; c22 = racc; accum_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (dr22) seen++;
    end
    dcheck("abort_no_ready", seen == 0, seen, 0);
    dcheck("abort_cleared", out22 === '0 && busy22 === 1'b0 && sat22 === 1'b0,
           longint'($signed(out22[0][0])), 0);
    run222("after_abort", ra, rb, racc, 1'b1, w1, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ctests + dtests, cfails + dfails);
    $finish;
  end

endmodule
